// File: rtl/mul_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pipe_pkg
//  Description : Shared types and constants for the FP multiplier issue
//                scheduler. Holds the IEEE exception flag layout, the default
//                pipeline depth and counter width, and the tag-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_pipe_pkg;

    // Default number of datapath register stages gated by mul_en.
    localparam int c_pipe_d = 3;

    // Default width of the performance counters.
    localparam int c_cnt_w  = 16;

    // IEEE exception flags as delivered by the final datapath stage.
    typedef struct packed {
        logic nv;   // invalid operation
        logic dz;   // divide by zero
        logic of;   // overflow
        logic uf;   // underflow
        logic nx;   // inexact
    } flag_t;

    // Width of a requester index. A single requester still needs one bit so
    // that the tag vectors never collapse to zero width.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_pipe_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Searches for the first asserted request
//                starting at the priority pointer and wrapping modulo NREQ.
//                The pointer moves to one past the winner on every accepted
//                grant and holds otherwise.
//  Ports       : clk, rst_n      clock, synchronous active-low reset
//                req[NREQ]       request vector
//                en              grant permitted this cycle
//                grant[NREQ]     one-hot grant (all zero when en=0)
//                grant_idx       index of the winning requester
//                accept          a grant was issued this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import mul_pipe_pkg::*;
#(
    parameter  int NREQ    = 2,
    localparam int c_tag_w = tag_w(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic               en,
    output logic [NREQ-1:0]    grant,
    output logic [c_tag_w-1:0] grant_idx,
    output logic               accept
);

    logic [c_tag_w-1:0] r_ptr;
    logic [c_tag_w-1:0] w_idx;
    logic [c_tag_w-1:0] w_ptr_nxt;
    logic               w_found;

    // Two-pass search: first the requesters at or above the pointer, then
    // wrap around to the ones below it. Equivalent to a rotating priority
    // scan without needing a variable rotate.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (c_tag_w'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_idx   = c_tag_w'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i]) begin
                w_found = 1'b1;
                w_idx   = c_tag_w'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = en && w_found && (w_idx == c_tag_w'(i));
        end
    end

    assign accept    = en && w_found;
    assign grant_idx = w_idx;

    // The last requester wraps explicitly, since NREQ need not be a power of two.
    assign w_ptr_nxt = (w_idx == c_tag_w'(NREQ - 1)) ? '0 : w_idx + c_tag_w'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (accept) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_pipe_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pipe_sched
//  Description : Issue scheduler for the 3-stage FP multiplier pipeline.
//                Shares the pipeline between NREQ requesters round-robin,
//                tags each issued op, tracks it through the datapath stages,
//                and steers the result and IEEE flags back to the owner.
//                The whole pipe stalls when the retiring result is not
//                accepted; flush drops every op in flight.
//  Ports       : clk, rst_n                  clock, synchronous active-low reset
//                flush                       drop all in-flight ops
//                req_valid/req_ready         per-requester issue handshake
//                req_a/req_b                 packed operands, DATA_W per requester
//                mul_en                      stage enable to datapath regs
//                mul_in_valid/a/b            issue slot to datapath
//                mul_res/mul_flags           datapath final-stage outputs
//                resp_valid/resp_ready       per-requester result handshake
//                resp_res/resp_flags         shared result bus
//                busy                        any op in flight
//                cnt_issue/cnt_stall         performance counters
//  Revision    : 1.0  initial release
// ============================================================================
module mul_pipe_sched
    import mul_pipe_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = 32,
    parameter int PIPE_D = c_pipe_d,
    parameter int CNT_W  = c_cnt_w
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic                   mul_en,
    output logic                   mul_in_valid,
    output logic [DATA_W-1:0]      mul_in_a,
    output logic [DATA_W-1:0]      mul_in_b,
    input  logic [DATA_W-1:0]      mul_res,
    input  logic [4:0]             mul_flags,
    output logic [NREQ-1:0]        resp_valid,
    input  logic [NREQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]      resp_res,
    output logic [4:0]             resp_flags,
    output logic                   busy,
    output logic [CNT_W-1:0]       cnt_issue,
    output logic [CNT_W-1:0]       cnt_stall
);

    localparam int c_tag_w = tag_w(NREQ);

    // Occupancy and owner of each datapath stage; stage PIPE_D-1 lines up
    // with mul_res/mul_flags.
    logic [PIPE_D-1:0]  r_vld;
    logic [c_tag_w-1:0] r_tag [PIPE_D];

    logic [CNT_W-1:0]   r_cnt_issue;
    logic [CNT_W-1:0]   r_cnt_stall;

    logic [NREQ-1:0]    w_resp_valid;
    logic [NREQ-1:0]    w_grant;
    logic [c_tag_w-1:0] w_idx;
    logic               w_accept;
    logic               w_stall;
    logic               w_issue_en;
    flag_t              w_flags;

    // ------------------------------------------------------------------
    // Response steering: the final-stage tag selects which requester sees
    // the result.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        assign w_resp_valid[gi] = r_vld[PIPE_D-1] && (r_tag[PIPE_D-1] == c_tag_w'(gi));
    end

    // A retiring op whose owner is not ready freezes the whole pipe. While
    // in reset the enable is forced high so the datapath flushes its
    // contents regardless of stale tracking state.
    assign w_stall    = |(w_resp_valid & ~resp_ready);
    assign mul_en     = !rst_n || !w_stall;
    assign w_issue_en = mul_en && !flush && rst_n;

    assign resp_valid = rst_n ? w_resp_valid : '0;
    assign w_flags    = mul_flags;
    assign resp_flags = w_flags;
    assign resp_res   = mul_res;
    assign busy       = rst_n && (|r_vld);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arbiter #(
        .NREQ      (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (w_issue_en),
        .grant     (w_grant),
        .grant_idx (w_idx),
        .accept    (w_accept)
    );

    assign req_ready    = w_grant;
    assign mul_in_valid = w_accept;

    // AND-OR operand select on the one-hot grant: drives zero when nothing
    // is accepted, so idle slots carry no stale operands.
    always_comb begin
        mul_in_a = '0;
        mul_in_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            mul_in_a = mul_in_a | (req_a[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
            mul_in_b = mul_in_b | (req_b[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
        end
    end

    // ------------------------------------------------------------------
    // Tracking pipeline, shifts in step with the datapath.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else if (mul_en) begin
            r_vld[0] <= w_accept;
            for (int s = 1; s < PIPE_D; s++) begin
                r_vld[s] <= r_vld[s-1];
            end
        end
    end

    // Tags are only meaningful alongside a set valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (mul_en) begin
            r_tag[0] <= w_idx;
            for (int s = 1; s < PIPE_D; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters: issue count wraps, stall count saturates.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_issue <= '0;
            r_cnt_stall <= '0;
        end else begin
            if (w_accept) begin
                r_cnt_issue <= r_cnt_issue + CNT_W'(1);
            end
            if (!mul_en && (r_cnt_stall != '1)) begin
                r_cnt_stall <= r_cnt_stall + CNT_W'(1);
            end
        end
    end

    assign cnt_issue = r_cnt_issue;
    assign cnt_stall = r_cnt_stall;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_resp_onehot0: assert property (@(posedge clk) $onehot0(resp_valid));
    a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready));
    a_ready_has_valid: assert property (@(posedge clk) (req_ready & ~req_valid) == '0);
    a_operands_hold: assert property (@(posedge clk)
        !mul_en |-> (!mul_in_valid && (mul_in_a == '0) && (mul_in_b == '0)));

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_pipe_sched
//  Description : Self-checking bench for mul_pipe_sched. A behavioural
//                multiplier pipeline sits behind the scheduler; a scoreboard
//                records the expected result at issue and compares it when
//                the matching response handshake occurs. A second instance
//                with three requesters covers pointer wrap and counter wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_pipe_sched;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int PD   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [1:0]      req_valid, req_ready, resp_valid, resp_ready;
    logic [63:0]     req_a, req_b;
    logic            mul_en, mul_in_valid, busy;
    logic [31:0]     mul_in_a, mul_in_b, mul_res, resp_res;
    logic [4:0]      mul_flags, resp_flags;
    logic [15:0]     cnt_issue, cnt_stall;

    // Three-requester instance
    logic            flush3;
    logic [2:0]      req_valid3, req_ready3, resp_valid3, resp_ready3;
    logic [95:0]     req_a3, req_b3;
    logic            mul_en3, mul_in_valid3, busy3;
    logic [31:0]     mul_in_a3, mul_in_b3, mul_res3, resp_res3;
    logic [4:0]      mul_flags3, resp_flags3;
    logic [7:0]      cnt_issue3, cnt_stall3;

    always #5 clk = ~clk;

    mul_pipe_sched #(.NREQ(NREQ), .DATA_W(DW), .PIPE_D(PD), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_en(mul_en), .mul_in_valid(mul_in_valid), .mul_in_a(mul_in_a), .mul_in_b(mul_in_b),
        .mul_res(mul_res), .mul_flags(mul_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_res(resp_res), .resp_flags(resp_flags),
        .busy(busy), .cnt_issue(cnt_issue), .cnt_stall(cnt_stall)
    );

    mul_pipe_sched #(.NREQ(3), .DATA_W(DW), .PIPE_D(PD), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_a(req_a3), .req_b(req_b3),
        .mul_en(mul_en3), .mul_in_valid(mul_in_valid3), .mul_in_a(mul_in_a3), .mul_in_b(mul_in_b3),
        .mul_res(mul_res3), .mul_flags(mul_flags3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_res(resp_res3), .resp_flags(resp_flags3),
        .busy(busy3), .cnt_issue(cnt_issue3), .cnt_stall(cnt_stall3)
    );

    // ------------------------------------------------------------------
    // Behavioural datapath: integer product plus flags derived from it.
    // ------------------------------------------------------------------
    function automatic logic [36:0] dp_f(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        p = a * b;
        return {p[31], p[30], a[0] & b[0], (p == 32'd0), ^p, p};
    endfunction

    logic [36:0] dp [PD];
    always @(posedge clk) begin
        if (mul_en) begin
            dp[0] <= dp_f(mul_in_a, mul_in_b);
            for (int s = 1; s < PD; s++) dp[s] <= dp[s-1];
        end
    end
    assign mul_res   = dp[PD-1][31:0];
    assign mul_flags = dp[PD-1][36:32];

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    logic        m_ptr = 1'b0;
    logic        m_g;
    logic        m_has;
    logic [1:0]  m_er;
    logic [31:0] m_a, m_b;
    logic [36:0] m_d;

    // Monitor: reference round-robin model plus scoreboard push/pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_ptr = 1'b0;
        end else begin
            m_has = 1'b1;
            if (req_valid[m_ptr])       m_g = m_ptr;
            else if (req_valid[~m_ptr]) m_g = ~m_ptr;
            else begin m_g = 1'b0; m_has = 1'b0; end
            m_er = (mul_en && !flush && m_has) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
            chk("arb_grant", req_ready, m_er);

            if ((resp_valid & resp_ready) != 2'b00) begin
                chk("sb_avail", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    m_e = sb.pop_front();
                    chk("resp_owner", resp_valid, m_e.id ? 2'b10 : 2'b01);
                    chk("resp_res", resp_res, m_e.res);
                    chk("resp_flags", resp_flags, m_e.flg);
                end
            end

            if (flush) sb.delete();

            if (m_er != 2'b00) begin
                m_a = m_g ? req_a[63:32] : req_a[31:0];
                m_b = m_g ? req_b[63:32] : req_b[31:0];
                chk("issue_a", mul_in_a, m_a);
                chk("issue_b", mul_in_b, m_b);
                m_d = dp_f(m_a, m_b);
                sb.push_back('{id: m_g, res: m_d[31:0], flg: m_d[36:32]});
                m_ptr = ~m_g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_ops();
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
    endtask

    task automatic drain();
        for (int w = 0; w < 20 && sb.size() != 0; w++) tick();
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        req_valid   = 2'b11;
        resp_ready  = 2'b11;
        rnd_ops();
        flush3      = 1'b0;
        req_valid3  = 3'b000;
        resp_ready3 = 3'b111;
        req_a3      = '0;
        req_b3      = '0;
        mul_res3    = '0;
        mul_flags3  = '0;

        // Reset values with requests pending
        repeat (2) tick();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mul_in_valid", mul_in_valid, 0);
        chk("rst_mul_en", mul_en, 1);
        chk("rst_busy", busy, 0);
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rst_cnt_issue", cnt_issue, 0);
        chk("rst_cnt_stall", cnt_stall, 0);
        tick();

        // 1: single requester, 8 back-to-back ops, latency 3
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin req_valid = 2'b01; rnd_ops(); end
            else req_valid = 2'b00;
            @(negedge clk);
            chk("t1_resp_valid", resp_valid, (k >= 3 && k <= 10) ? 2'b01 : 2'b00);
            tick();
        end
        @(negedge clk);
        chk("t1_cnt_issue", cnt_issue, 8);
        tick();

        // 2: both requesters valid; pointer is 1 after test 1
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            rnd_ops();
            @(negedge clk);
            chk("t2_alt", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        req_valid = 2'b00;
        drain();

        // 3: backpressure on requester 0 for 4 cycles
        req_valid = 2'b11;
        for (int w = 0; w < 10 && resp_valid != 2'b01; w++) begin
            rnd_ops();
            tick();
        end
        chk("t3_sync", resp_valid, 2'b01);
        resp_ready = 2'b10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_mul_en", mul_en, 0);
            chk("t3_req_ready", req_ready, 0);
            chk("t3_resp_valid", resp_valid, 2'b01);
            chk("t3_resp_hold", resp_res, sb[0].res);
            tick();
        end
        resp_ready = 2'b11;
        @(negedge clk);
        chk("t3_cnt_stall", cnt_stall, 4);
        tick();
        req_valid = 2'b00;
        drain();

        // 4: flush with 3 ops in flight
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            rnd_ops();
            tick();
        end
        flush = 1'b1;
        @(negedge clk);
        chk("t4_flush_ready", req_ready, 0);
        chk("t4_resp_in_flush", (resp_valid != 2'b00), 1);
        tick();
        flush     = 1'b0;
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_busy", busy, 0);
            chk("t4_no_resp", resp_valid, 0);
            tick();
        end
        chk("t4_sb", sb.size(), 0);

        // 5: reset mid-stream
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            rnd_ops();
            tick();
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_mul_in_valid", mul_in_valid, 0);
        chk("t5_mul_en", mul_en, 1);
        chk("t5_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_cnt_issue", cnt_issue, 0);
        chk("t5_cnt_stall", cnt_stall, 0);
        chk("t5_first_grant", req_ready, 2'b01);
        chk("t5_busy_after", busy, 0);
        tick();
        repeat (3) begin rnd_ops(); tick(); end
        req_valid = 2'b00;
        drain();

        // 6: three requesters, pointer wrap and counter wrap (8-bit counter)
        req_valid3 = 3'b011;
        @(negedge clk);
        chk("t6_g0", req_ready3, 3'b001);
        tick();
        @(negedge clk);
        chk("t6_g1", req_ready3, 3'b010);
        tick();
        req_valid3 = 3'b001;
        @(negedge clk);
        chk("t6_wrap_grant", req_ready3, 3'b001);
        tick();
        req_valid3 = 3'b111;
        @(negedge clk);
        chk("t6_ptr", req_ready3, 3'b010);
        tick();
        repeat (251) tick();
        @(negedge clk);
        chk("t6_cnt255", cnt_issue3, 255);
        tick();
        req_valid3 = 3'b000;
        @(negedge clk);
        chk("t6_cnt_wrap", cnt_issue3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
